if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 86 ++++++++
 tb/tb_if_id_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, halt detection and
// flush/stall priority handling for a 16-bit pipeline.
module if_id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [15:0] PC_incr,
    input  logic        IMemStall,
    input  logic        HazardStall,
    input  logic        DMemStall,
    input  logic        Flush,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_PC_incr,
    output logic        if_id_valid,
    output logic        pcHold,
    output logic        fetchHalted
);

    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SKID   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] skid_reg;
    logic        load;

    function automatic logic is_halt(input logic [15:0] w);
        return (w[15:11] == 5'b00000);
    endfunction

    // Flush beats the hazard stall, but a data-memory stall freezes everything.
    assign load        = ~DMemStall & (Flush | ~HazardStall);
    assign pcHold      = (state_reg != RUN) | IMemStall | DMemStall;
    assign fetchHalted = (state_reg == HALTED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_instr   <= NOP;
            if_id_PC_incr <= 16'h0000;
            if_id_valid   <= 1'b0;
            skid_reg      <= 32'h0000_0000;
            state_reg     <= RUN;
        end else if (load) begin
            if (Flush) begin
                if_id_instr   <= NOP;
                if_id_PC_incr <= 16'h0000;
                if_id_valid   <= 1'b0;
                skid_reg      <= 32'h0000_0000;
                state_reg     <= RUN;
            end else begin
                case (state_reg)
                    SKID: begin
                        if_id_instr   <= skid_reg[31:16];
                        if_id_PC_incr <= skid_reg[15:0];
                        if_id_valid   <= 1'b1;
                        state_reg     <= is_halt(skid_reg[31:16]) ? HALTED : RUN;
                    end
                    RUN: begin
                        if (!IMemStall) begin
                            if_id_instr   <= instr;
                            if_id_PC_incr <= PC_incr;
                            if_id_valid   <= 1'b1;
                            state_reg     <= is_halt(instr) ? HALTED : RUN;
                        end else begin
                            if_id_instr <= NOP;
                            if_id_valid <= 1'b0;
                        end
                    end
                    default: begin
                        if_id_instr <= NOP;
                        if_id_valid <= 1'b0;
                    end
                endcase
            end
        end else if (!DMemStall && state_reg == RUN && !IMemStall) begin
            // The PC already advanced past this word, so park it until decode frees up.
            skid_reg  <= {instr, PC_incr};
            state_reg <= SKID;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed scenarios then randomized traffic,
// checked against a queue-based reference model of the fetch/decode handoff.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [15:0] PC_incr;
    logic        IMemStall;
    logic        HazardStall;
    logic        DMemStall;
    logic        Flush;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_PC_incr;
    logic        if_id_valid;
    logic        pcHold;
    logic        fetchHalted;

    if_id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .PC_incr      (PC_incr),
        .IMemStall    (IMemStall),
        .HazardStall  (HazardStall),
        .DMemStall    (DMemStall),
        .Flush        (Flush),
        .if_id_instr  (if_id_instr),
        .if_id_PC_incr(if_id_PC_incr),
        .if_id_valid  (if_id_valid),
        .pcHold       (pcHold),
        .fetchHalted  (fetchHalted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] pc;
        logic        valid;
        logic        halted;
        logic        hold;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t rst_q[$];
    event rst_ev;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model: the pending word and the halt condition as plain data.
    logic [15:0] m_ins = 16'h0800;
    logic [15:0] m_pc  = 16'h0000;
    logic        m_valid  = 1'b0;
    bit          m_halted = 1'b0;
    logic [31:0] m_skid[$];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s txn=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    function automatic exp_t snapshot(input int idx);
        exp_t e;
        e.ins    = m_ins;
        e.pc     = m_pc;
        e.valid  = m_valid;
        e.halted = m_halted;
        e.hold   = m_halted | (m_skid.size() != 0) | IMemStall | DMemStall;
        e.idx    = idx;
        return e;
    endfunction

    task automatic model_reset();
        m_ins = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0; m_halted = 0;
        m_skid.delete();
    endtask

    task automatic model_edge();
        logic [31:0] w;
        if (!rst) begin
            model_reset();
        end else if (DMemStall) begin
            // frozen
        end else if (Flush) begin
            model_reset();
        end else if (HazardStall) begin
            if (!m_halted && m_skid.size() == 0 && !IMemStall)
                m_skid.push_back({instr, PC_incr});
        end else if (m_skid.size() != 0) begin
            w = m_skid.pop_front();
            m_ins = w[31:16]; m_pc = w[15:0]; m_valid = 1'b1;
            m_halted = (w[31:27] == 5'b00000);
        end else if (m_halted || IMemStall) begin
            m_ins = 16'h0800; m_valid = 1'b0;
        end else begin
            m_ins = instr; m_pc = PC_incr; m_valid = 1'b1;
            m_halted = (instr[15:11] == 5'b00000);
        end
    endtask

    task automatic drive(input bit r, input logic [15:0] i, input logic [15:0] p,
                         input bit ims, input bit hs, input bit ds, input bit fl);
        @(negedge clk);
        rst = r; instr = i; PC_incr = p;
        IMemStall = ims; HazardStall = hs; DMemStall = ds; Flush = fl;
        model_edge();
        exp_q.push_back(snapshot(txn));
        txn++;
    endtask

    // Monitor: every edge that has a pending expectation is compared here.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("if_id_instr",   e.idx, if_id_instr,   e.ins);
                chk("if_id_PC_incr", e.idx, if_id_PC_incr, e.pc);
                chk("if_id_valid",   e.idx, {15'd0, if_id_valid}, {15'd0, e.valid});
                chk("fetchHalted",   e.idx, {15'd0, fetchHalted}, {15'd0, e.halted});
                chk("pcHold",        e.idx, {15'd0, pcHold},      {15'd0, e.hold});
                $display("txn %0d: instr=%h pc=%h valid=%b halted=%b hold=%b",
                         e.idx, if_id_instr, if_id_PC_incr, if_id_valid, fetchHalted, pcHold);
            end
        end
    end

    // Monitor for the mid-cycle asynchronous reset response.
    initial begin
        exp_t e;
        forever begin
            @(rst_ev);
            if (rst_q.size() > 0) begin
                e = rst_q.pop_front();
                chk("async_rst_instr", e.idx, if_id_instr,   e.ins);
                chk("async_rst_pc",    e.idx, if_id_PC_incr, e.pc);
                chk("async_rst_valid", e.idx, {15'd0, if_id_valid}, {15'd0, e.valid});
                chk("async_rst_halt",  e.idx, {15'd0, fetchHalted}, {15'd0, e.halted});
                chk("async_rst_hold",  e.idx, {15'd0, pcHold},      {15'd0, e.hold});
                $display("async reset txn %0d: instr=%h pc=%h valid=%b hold=%b",
                         e.idx, if_id_instr, if_id_PC_incr, if_id_valid, pcHold);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ri;
        rst = 1'b0; instr = 16'h4000; PC_incr = 16'h0000;
        IMemStall = 0; HazardStall = 0; DMemStall = 0; Flush = 0;
        model_reset();

        drive(0, 16'h4000, 16'h0000, 0, 0, 0, 0);
        drive(0, 16'h4000, 16'h0000, 0, 0, 0, 0);
        // streaming
        drive(1, 16'h4001, 16'h0002, 0, 0, 0, 0);
        drive(1, 16'h4002, 16'h0004, 0, 0, 0, 0);
        // hazard skid and release
        drive(1, 16'h4003, 16'h0006, 0, 1, 0, 0);
        drive(1, 16'h4004, 16'h0008, 0, 0, 0, 0);
        drive(1, 16'h4004, 16'h0008, 0, 0, 0, 0);
        // flush while in SKID
        drive(1, 16'h4005, 16'h000A, 0, 1, 0, 0);
        drive(1, 16'h4006, 16'h000C, 0, 1, 0, 1);
        drive(1, 16'h4010, 16'h0020, 0, 0, 0, 0);
        // halt, NOP loads while halted, flush out of halt
        drive(1, 16'h0000, 16'h0022, 0, 0, 0, 0);
        drive(1, 16'h4011, 16'h0024, 0, 0, 0, 0);
        drive(1, 16'h4011, 16'h0024, 0, 0, 0, 0);
        drive(1, 16'h4011, 16'h0024, 0, 0, 0, 1);
        drive(1, 16'h4012, 16'h0030, 0, 0, 0, 0);
        // DMemStall with Flush in SKID for three cycles
        drive(1, 16'h4013, 16'h0032, 0, 1, 0, 0);
        repeat (3) drive(1, 16'h4777, 16'h0777, 0, 1, 1, 1);
        drive(1, 16'h4014, 16'h0034, 0, 0, 0, 0);
        // asynchronous reset mid-cycle in SKID
        drive(1, 16'h4015, 16'h0036, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1; instr = 16'h4016; PC_incr = 16'h0038;
        IMemStall = 1; HazardStall = 1; DMemStall = 0; Flush = 0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        rst_q.push_back(snapshot(txn));
        ->rst_ev;
        exp_q.push_back(snapshot(txn));
        txn++;
        drive(1, 16'h4017, 16'h003A, 0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ri = 16'($urandom);
            if ($urandom_range(0, 99) < 5) ri[15:11] = 5'b00000;
            else if (ri[15:11] == 5'b00000) ri[14] = 1'b1;
            drive($urandom_range(0, 199) != 0, ri, 16'($urandom),
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", txn, 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
